pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter LOAD_STALL_CYCLES, default 1, legal 1..3: number of stall cycles inserted for a load-use hazard.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ID_rs1  input  `REG_ADDR_LEN  first source register of the instruction held in IF/ID.
REQ-005 ID_rs2  input  `REG_ADDR_LEN  second source register of the instruction held in IF/ID.
REQ-006 ID_halt  input  1  instruction in IF/ID is a halt.
REQ-007 EX_mem_read  input  1  instruction in EX is a load.
REQ-008 EX_rd  input  `REG_ADDR_LEN  destination register of the instruction in EX.
REQ-009 EX_branch_taken  input  1  branch or jump in EX resolved taken this cycle.
REQ-010 mem_busy  input  1  data memory not ready; pipeline must freeze.
REQ-011 pc_write_en  output  1  PC register load enable.
REQ-012 if_id_write_en  output  1  IF/ID register load enable.
REQ-013 if_id_flush  output  1  IF/ID loads zero (NOP) at next edge.
REQ-014 id_ex_write_en  output  1  ID/EX register load enable.
REQ-015 id_ex_bubble  output  1  ID/EX loads a NOP instead of decoded controls.
REQ-016 halted  output  1  core halted.
REQ-017 stall_count  output  16  saturating count of stall and freeze cycles.
REQ-018 flush_count  output  16  saturating count of taken-branch flushes.

Function
REQ-019 The FSM SHALL have exactly these states: RUN, LOAD_STALL, HALTED; all outputs are combinational from the state, the stall counter and the inputs.
REQ-020 A load-use hazard SHALL be EX_mem_read=1 and EX_rd!=0 and (EX_rd==ID_rs1 or EX_rd==ID_rs2).
REQ-021 Event priority SHALL be: mem_busy > EX_branch_taken > load-use > ID_halt.
REQ-022 In RUN with no event present: pc_write_en=if_id_write_en=id_ex_write_en=1, if_id_flush=id_ex_bubble=0.
REQ-023 mem_busy=1 in RUN or LOAD_STALL SHALL drive all write enables, if_id_flush and id_ex_bubble to 0; state and stall counter hold; stall_count increments.
REQ-024 EX_branch_taken=1 (not busy) in RUN or LOAD_STALL SHALL drive pc_write_en=1, if_id_flush=1, id_ex_bubble=1, id_ex_write_en=1; next state RUN; flush_count increments. A pending stall is abandoned.
REQ-025 A load-use hazard in RUN SHALL drive pc_write_en=0, if_id_write_en=0, id_ex_bubble=1, id_ex_write_en=1; stall_count increments.
REQ-026 If LOAD_STALL_CYCLES>1, a load-use hazard SHALL also load the stall counter with LOAD_STALL_CYCLES-1 and select next state LOAD_STALL.
REQ-027 LOAD_STALL SHALL drive the same outputs as REQ-025 regardless of the hazard inputs.
REQ-028 In LOAD_STALL, each non-busy cycle SHALL decrement the stall counter; when the counter is 1, next state is RUN.
REQ-029 ID_halt=1 in RUN with no higher-priority event SHALL drive pc_write_en=0 and if_id_write_en=0, keep id_ex_write_en=1 with id_ex_bubble=1, and select next state HALTED.
REQ-030 HALTED SHALL drive all write enables to 0 and halted=1, ignore every input, and be left only by reset.
REQ-031 stall_count and flush_count SHALL saturate at 16'hFFFF and never wrap.

Reset
REQ-032 While rst=1: state=RUN, stall counter=0, stall_count=0, flush_count=0, halted=0, and all write enables, if_id_flush and id_ex_bubble=0.
REQ-033 Reset asserted mid-stall or mid-freeze SHALL abort immediately; the first cycle after deassertion behaves per REQ-022.

Structure
REQ-034 `REG_ADDR_LEN and the FSM state encoding SHALL live in the shared defines file; no local redefinition.
REQ-035 Hazard detection (REQ-020) SHALL be a sub-module load_use_detect; the FSM and counters stay in pipeline_hazard_ctrl.

Verification
REQ-036 EX_mem_read=1, EX_rd=3, ID_rs2=3, LOAD_STALL_CYCLES=2 -> two cycles with pc_write_en=0 and id_ex_bubble=1, then RUN; stall_count=2.
REQ-037 Load-use hazard and EX_branch_taken=1 in the same cycle -> if_id_flush=1, pc_write_en=1, no stall; flush_count=1, stall_count=0.
REQ-038 mem_busy=1 for 3 cycles inside LOAD_STALL -> all enables 0, stall counter held, stall_count +3, then the remaining stall cycle completes.
REQ-039 ID_halt=1 with EX_branch_taken=1 -> flush and no halt; ID_halt=1 alone -> halted=1 held for 10 cycles with all enables 0.
REQ-040 EX_rd=0 with matching rs1=0 and EX_mem_read=1 -> no stall.
REQ-041 Preload stall_count=16'hFFFE, then 3 stall cycles -> stall_count=16'hFFFF; rst pulse mid-LOAD_STALL -> state RUN, counts 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared register-address width, FSM encoding and counter helper
package pipeline_hazard_ctrl_pkg;

    localparam int REG_ADDR_LEN = 5;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        HALTED     = 2'd2
    } hz_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// rtl/pipeline_hazard_ctrl_load_use_detect.sv - load-use RAW hazard between EX load and IF/ID sources
module load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic                    i_ex_mem_read,
    input  logic [REG_ADDR_LEN-1:0] i_ex_rd,
    input  logic [REG_ADDR_LEN-1:0] i_id_rs1,
    input  logic [REG_ADDR_LEN-1:0] i_id_rs2,
    output logic                    o_load_use
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign o_load_use = i_ex_mem_read && (i_ex_rd != '0) &&
                        ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush/halt sequencer with saturating event counters
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_ADDR_LEN-1:0] ID_rs1,
    input  logic [REG_ADDR_LEN-1:0] ID_rs2,
    input  logic                    ID_halt,
    input  logic                    EX_mem_read,
    input  logic [REG_ADDR_LEN-1:0] EX_rd,
    input  logic                    EX_branch_taken,
    input  logic                    mem_busy,
    output logic                    pc_write_en,
    output logic                    if_id_write_en,
    output logic                    if_id_flush,
    output logic                    id_ex_write_en,
    output logic                    id_ex_bubble,
    output logic                    halted,
    output logic [15:0]             stall_count,
    output logic [15:0]             flush_count
);

    localparam logic [1:0] STALL_RELOAD = 2'(LOAD_STALL_CYCLES - 1);

    hz_state_t  r_state;
    hz_state_t  w_next_state;
    logic [1:0] r_stall_cnt;
    logic [1:0] w_next_cnt;
    logic       w_load_use;
    logic       w_stall_inc;
    logic       w_flush_inc;

    load_use_detect u_load_use_detect (
        .i_ex_mem_read (EX_mem_read),
        .i_ex_rd       (EX_rd),
        .i_id_rs1      (ID_rs1),
        .i_id_rs2      (ID_rs2),
        .o_load_use    (w_load_use)
    );

    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_stall_cnt;
        w_stall_inc    = 1'b0;
        w_flush_inc    = 1'b0;
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_write_en = 1'b0;
        id_ex_bubble   = 1'b0;
        halted         = 1'b0;
        // Outputs are gated while reset is held so the pipeline cannot advance.
        if (!rst) begin
            case (r_state)
                RUN: begin
                    if (mem_busy) begin
                        w_stall_inc = 1'b1;
                    end else if (EX_branch_taken) begin
                        pc_write_en    = 1'b1;
                        if_id_write_en = 1'b1;
                        if_id_flush    = 1'b1;
                        id_ex_write_en = 1'b1;
                        id_ex_bubble   = 1'b1;
                        w_flush_inc    = 1'b1;
                    end else if (w_load_use) begin
                        id_ex_write_en = 1'b1;
                        id_ex_bubble   = 1'b1;
                        w_stall_inc    = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            w_next_cnt   = STALL_RELOAD;
                            w_next_state = LOAD_STALL;
                        end
                    end else if (ID_halt) begin
                        id_ex_write_en = 1'b1;
                        id_ex_bubble   = 1'b1;
                        w_next_state   = HALTED;
                    end else begin
                        pc_write_en    = 1'b1;
                        if_id_write_en = 1'b1;
                        id_ex_write_en = 1'b1;
                    end
                end
                LOAD_STALL: begin
                    if (mem_busy) begin
                        w_stall_inc = 1'b1;
                    end else if (EX_branch_taken) begin
                        pc_write_en    = 1'b1;
                        if_id_write_en = 1'b1;
                        if_id_flush    = 1'b1;
                        id_ex_write_en = 1'b1;
                        id_ex_bubble   = 1'b1;
                        w_flush_inc    = 1'b1;
                        w_next_cnt     = 2'd0;
                        w_next_state   = RUN;
                    end else begin
                        id_ex_write_en = 1'b1;
                        id_ex_bubble   = 1'b1;
                        w_stall_inc    = 1'b1;
                        w_next_cnt     = r_stall_cnt - 2'd1;
                        if (r_stall_cnt <= 2'd1) begin
                            w_next_state = RUN;
                        end
                    end
                end
                HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    w_next_state = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_stall_cnt <= 2'd0;
            stall_count <= 16'd0;
            flush_count <= 16'd0;
        end else begin
            r_state     <= w_next_state;
            r_stall_cnt <= w_next_cnt;
            if (w_stall_inc) begin
                stall_count <= sat_inc(stall_count);
            end
            if (w_flush_inc) begin
                flush_count <= sat_inc(flush_count);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - table-driven and sequence checks for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  ID_rs1 = '0;
    logic [4:0]  ID_rs2 = '0;
    logic        ID_halt = 1'b0;
    logic        EX_mem_read = 1'b0;
    logic [4:0]  EX_rd = '0;
    logic        EX_branch_taken = 1'b0;
    logic        mem_busy = 1'b0;
    logic        pc_write_en, if_id_write_en, if_id_flush;
    logic        id_ex_write_en, id_ex_bubble, halted;
    logic [15:0] stall_count, flush_count;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .ID_rs1          (ID_rs1),
        .ID_rs2          (ID_rs2),
        .ID_halt         (ID_halt),
        .EX_mem_read     (EX_mem_read),
        .EX_rd           (EX_rd),
        .EX_branch_taken (EX_branch_taken),
        .mem_busy        (mem_busy),
        .pc_write_en     (pc_write_en),
        .if_id_write_en  (if_id_write_en),
        .if_id_flush     (if_id_flush),
        .id_ex_write_en  (id_ex_write_en),
        .id_ex_bubble    (id_ex_bubble),
        .halted          (halted),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    // {pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en, id_ex_bubble, halted}
    localparam logic [5:0] O_NORM   = 6'b110100;
    localparam logic [5:0] O_STALL  = 6'b000110;
    localparam logic [5:0] O_FLUSH  = 6'b111110;
    localparam logic [5:0] O_FREEZE = 6'b000000;
    localparam logic [5:0] O_HALTED = 6'b000001;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        halt;
        logic        mr;
        logic [4:0]  rd;
        logic        br;
        logic        busy;
        logic [5:0]  exp_out;
        logic [15:0] exp_sc;
        logic [15:0] exp_fc;
    } vec_t;

    vec_t tbl [24];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic halt,
                                input logic mr, input logic [4:0] rd, input logic br, input logic busy,
                                input logic [5:0] eo, input logic [15:0] sc, input logic [15:0] fc);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.halt = halt; v.mr = mr; v.rd = rd;
        v.br = br; v.busy = busy; v.exp_out = eo; v.exp_sc = sc; v.exp_fc = fc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        ID_rs1 = v.rs1; ID_rs2 = v.rs2; ID_halt = v.halt; EX_mem_read = v.mr;
        EX_rd = v.rd; EX_branch_taken = v.br; mem_busy = v.busy;
    endtask

    task automatic idle();
        ID_rs1 = 5'd1; ID_rs2 = 5'd2; ID_halt = 1'b0; EX_mem_read = 1'b0;
        EX_rd = 5'd5; EX_branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic check(input string name, input logic [5:0] eo, input logic [15:0] sc, input logic [15:0] fc);
        logic [5:0] got;
        got = {pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en, id_ex_bubble, halted};
        n_vec++;
        if (got !== eo || stall_count !== sc || flush_count !== fc) begin
            n_err++;
            $display("FAIL %s: outs=%b sc=%h fc=%h, required outs=%b sc=%h fc=%h",
                     name, got, stall_count, flush_count, eo, sc, fc);
        end
    endtask

    initial begin
        tbl[0]  = mk(5'd1, 5'd2, 0, 0, 5'd5, 0, 0, O_NORM,   16'd0,  16'd0);
        tbl[1]  = mk(5'd1, 5'd3, 0, 1, 5'd3, 0, 0, O_STALL,  16'd0,  16'd0);
        tbl[2]  = mk(5'd1, 5'd2, 0, 0, 5'd5, 0, 0, O_STALL,  16'd1,  16'd0);
        tbl[3]  = mk(5'd1, 5'd2, 0, 0, 5'd5, 0, 0, O_NORM,   16'd2,  16'd0);
        tbl[4]  = mk(5'd3, 5'd2, 0, 1, 5'd3, 1, 0, O_FLUSH,  16'd2,  16'd0);
        tbl[5]  = mk(5'd1, 5'd2, 0, 0, 5'd5, 0, 0, O_NORM,   16'd2,  16'd1);
        tbl[6]  = mk(5'd0, 5'd2, 0, 1, 5'd0, 0, 0, O_NORM,   16'd2,  16'd1);
        tbl[7]  = mk(5'd1, 5'd2, 0, 0, 5'd5, 0, 1, O_FREEZE, 16'd2,  16'd1);
        tbl[8]  = mk(5'd7, 5'd2, 0, 1, 5'd7, 0, 0, O_STALL,  16'd3,  16'd1);
        tbl[9]  = mk(5'd7, 5'd2, 0, 1, 5'd7, 0, 1, O_FREEZE, 16'd4,  16'd1);
        tbl[10] = mk(5'd1, 5'd2, 0, 0, 5'd5, 0, 1, O_FREEZE, 16'd5,  16'd1);
        tbl[11] = mk(5'd1, 5'd2, 0, 0, 5'd5, 1, 1, O_FREEZE, 16'd6,  16'd1);
        tbl[12] = mk(5'd1, 5'd2, 0, 0, 5'd5, 0, 0, O_STALL,  16'd7,  16'd1);
        tbl[13] = mk(5'd1, 5'd2, 0, 0, 5'd5, 0, 0, O_NORM,   16'd8,  16'd1);
        tbl[14] = mk(5'd1, 5'd4, 0, 1, 5'd4, 0, 0, O_STALL,  16'd8,  16'd1);
        tbl[15] = mk(5'd1, 5'd2, 0, 0, 5'd5, 1, 0, O_FLUSH,  16'd9,  16'd1);
        tbl[16] = mk(5'd1, 5'd2, 0, 0, 5'd5, 0, 0, O_NORM,   16'd9,  16'd2);
        tbl[17] = mk(5'd1, 5'd2, 1, 0, 5'd5, 1, 0, O_FLUSH,  16'd9,  16'd2);
        tbl[18] = mk(5'd1, 5'd2, 1, 0, 5'd5, 0, 1, O_FREEZE, 16'd9,  16'd3);
        tbl[19] = mk(5'd2, 5'd6, 1, 1, 5'd2, 0, 0, O_STALL,  16'd10, 16'd3);
        tbl[20] = mk(5'd1, 5'd2, 1, 0, 5'd5, 0, 0, O_STALL,  16'd11, 16'd3);
        tbl[21] = mk(5'd1, 5'd2, 1, 0, 5'd5, 0, 0, O_STALL,  16'd12, 16'd3);
        tbl[22] = mk(5'd1, 5'd2, 0, 0, 5'd5, 1, 1, O_HALTED, 16'd12, 16'd3);
        tbl[23] = mk(5'd3, 5'd2, 1, 1, 5'd3, 0, 0, O_HALTED, 16'd12, 16'd3);

        #1 rst = 1'b1;
        #2 check("reset_state", O_FREEZE, 16'd0, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check($sformatf("vec%0d", i), tbl[i].exp_out, tbl[i].exp_sc, tbl[i].exp_fc);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 10; i++) begin
            ID_halt = i[0]; mem_busy = i[1]; EX_branch_taken = i[2];
            @(negedge clk);
            check($sformatf("halt_hold%0d", i), O_HALTED, 16'd12, 16'd3);
            @(posedge clk); #1;
        end

        // Reset from HALTED, then a freeze interrupted by reset.
        idle();
        rst = 1'b1;
        #1 check("rst_from_halt", O_FREEZE, 16'd0, 16'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        mem_busy = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1 check("rst_mid_freeze", O_FREEZE, 16'd0, 16'd0);
        @(negedge clk); rst = 1'b0; mem_busy = 1'b0;
        #1 check("after_freeze_rst", O_NORM, 16'd0, 16'd0);
        @(posedge clk); #1;

        // Reset pulse in the middle of LOAD_STALL.
        EX_mem_read = 1'b1; EX_rd = 5'd9; ID_rs1 = 5'd9;
        @(negedge clk);
        check("ls_enter", O_STALL, 16'd0, 16'd0);
        @(posedge clk); #1;
        idle();
        #1 check("ls_inside", O_STALL, 16'd1, 16'd0);
        rst = 1'b1;
        #1 check("rst_mid_stall", O_FREEZE, 16'd0, 16'd0);
        @(negedge clk); rst = 1'b0;
        #1 check("after_stall_rst", O_NORM, 16'd0, 16'd0);
        @(posedge clk); #1;
        check("after_stall_rst2", O_NORM, 16'd0, 16'd0);

        // Drive stall_count to FFFE with freeze cycles, then three more must saturate.
        mem_busy = 1'b1;
        repeat (65534) @(posedge clk);
        #1 check("sat_preload", O_FREEZE, 16'hFFFE, 16'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("sat%0d", i), O_FREEZE, 16'hFFFF, 16'd0);
        end
        mem_busy = 1'b0;
        #1 check("sat_release", O_NORM, 16'hFFFF, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
